mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: RAM_WORDS, 256, data RAM depth in 32-bit words; power of two, max 256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 AluRes_i  input  32  effective address / ALU result from EX/MEM.
REQ-005 Op2_i  input  32  store data.
REQ-006 PC_i  input  32  instruction PC.
REQ-007 MemWr_i, MemRd_i, ByteRd_i  input  1 each  store, load, byte-load strobes.
REQ-008 MemtoReg_i  input  2  writeback source select, passed through.
REQ-009 RegWr_i  input  1  register write enable, passed through.
REQ-010 Rf_i  input  5  destination register, passed through.
REQ-011 MemData_o  output  32  registered load result.
REQ-012 AluRes_o, PC_o  output  32 each  registered copies of AluRes_i, PC_i.
REQ-013 MemtoReg_o  output  2; RegWr_o  output  1; Rf_o  output  5: registered pass-through.
REQ-014 leds_o  output  8  LED register.
REQ-015 digits_o  output  12  seven-segment digit register.
REQ-016 irq_o  output  1  timer interrupt request.

Function
REQ-017 Address map: RAM 0x00000000 to 4*RAM_WORDS-1; TH 0x40000000; TL 0x40000004; TCON 0x40000008 (bit0 enable, bit1 irq-enable, bit2 irq-status); LEDs 0x4000000C; digits 0x40000010; systick 0x40000014 (read-only).
REQ-018 RAM index is AluRes_i[9:2]; address bits [1:0] are ignored for word access.
REQ-019 RAM read is combinational in the MEM cycle; the result is registered into MemData_o at the next edge, giving 1-cycle latency to WB.
REQ-020 RAM write: word-wide, on the rising edge when MemWr_i=1 and the address is in RAM range.
REQ-021 Same-cycle read and write to the same word returns the pre-write value.
REQ-022 ByteRd_i=1 with MemRd_i=1 selects byte AluRes_i[1:0] (little-endian: 0 gives bits[7:0]) and zero-extends it to 32 bits.
REQ-023 MemRd_i=0 gives MemData_o=0.
REQ-024 Unmapped read gives 0; unmapped write is ignored.
REQ-025 MMIO reads return the register value zero-extended.
REQ-026 MMIO writes use Op2_i, truncated to the register width.
REQ-027 Timer: when TCON[0]=1, each cycle TL increments by 1; when TL=0xFFFFFFFF, TL reloads TH instead of incrementing, and TCON[2] is set if TCON[1]=1.
REQ-028 A software write to TL or TCON in the same cycle as count/overflow takes priority; the count/overflow update is discarded for that cycle.
REQ-029 systick increments every cycle and wraps from 0xFFFFFFFF to 0; writes to it are ignored.
REQ-030 All pass-through outputs are registered with exactly 1-cycle latency; there is no stall or flush input.

Reset
REQ-031 On reset at the rising edge: all outputs become 0, and TH, TL, TCON, leds, digits and systick become 0.
REQ-032 RAM contents are unchanged by reset.
REQ-033 A store coincident with reset is discarded.
REQ-034 Reset asserted while the timer is counting stops the count immediately.

Configuration
REQ-035 Macro MEM_TIMER_IRQ_EN defined: irq_o = TCON[1] & TCON[2], registered; software clears the request by writing 0 to TCON[2].
REQ-036 MEM_TIMER_IRQ_EN undefined: irq_o is tied to 0 and TCON[2] never sets; TH, TL and TCON[1:0] behave otherwise unchanged.

Verification
REQ-037 Store 0x12345678 to 0x00000010, then word load from 0x10 -> MemData_o=0x12345678 one cycle after the load.
REQ-038 ByteRd load from 0x00000012 after REQ-037 -> MemData_o=0x00000034; load from 0x13 -> 0x00000012.
REQ-039 Write TH=0xFFFFFFFE, TL=0xFFFFFFFE, TCON=3 -> TL reaches 0xFFFFFFFF, then reloads 0xFFFFFFFE; with the macro defined, irq_o=1 from the cycle after reload; writing TCON=3 clears it.
REQ-040 Write TL=5 in the same cycle as a counting tick -> TL=5 next cycle, not 6.
REQ-041 Store 0xA5 to 0x4000000C and 0xFFF to 0x40000010, then load 0x4000000C -> leds_o=0xA5, digits_o=0xFFF, MemData_o=0x000000A5.
REQ-042 Pulse reset mid-count with leds=0xA5 -> all outputs 0 next cycle and RAM word 0x10 still reads 0x12345678.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: word-addressed data RAM, timer/LED/digit/systick MMIO, registered MEM/WB outputs.
// Optional build macro MEM_TIMER_IRQ_EN enables the timer interrupt request (irq_o); without it irq_o is 0.
module mem_stage #(
    parameter int RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] AluRes_i,
    input  logic [31:0] Op2_i,
    input  logic [31:0] PC_i,
    input  logic        MemWr_i,
    input  logic        MemRd_i,
    input  logic        ByteRd_i,
    input  logic [1:0]  MemtoReg_i,
    input  logic        RegWr_i,
    input  logic [4:0]  Rf_i,
    output logic [31:0] MemData_o,
    output logic [31:0] AluRes_o,
    output logic [31:0] PC_o,
    output logic [1:0]  MemtoReg_o,
    output logic        RegWr_o,
    output logic [4:0]  Rf_o,
    output logic [7:0]  leds_o,
    output logic [11:0] digits_o,
    output logic        irq_o
);

    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    // MMIO word addresses (byte address >> 2)
    localparam logic [29:0] TH_WA      = 30'h1000_0000;
    localparam logic [29:0] TL_WA      = 30'h1000_0001;
    localparam logic [29:0] TCON_WA    = 30'h1000_0002;
    localparam logic [29:0] LED_WA     = 30'h1000_0003;
    localparam logic [29:0] DIG_WA     = 30'h1000_0004;
    localparam logic [29:0] SYSTICK_WA = 30'h1000_0005;

    logic [31:0] ram_q [RAM_WORDS];

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  leds_q, leds_d;
    logic [11:0] digits_q, digits_d;
    logic [31:0] systick_q, systick_d;
    logic        irq_q, irq_d;
    logic [31:0] memdata_q, memdata_d;
    logic [31:0] alures_q, alures_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  memtoreg_q, memtoreg_d;
    logic        regwr_q, regwr_d;
    logic [4:0]  rf_q, rf_d;

    logic [AW-1:0] ram_idx_s;
    logic [29:0]   word_addr_s;
    logic          in_ram_s;
    logic          wr_en_s;
    logic          ram_we_s;
    logic          wr_th_s, wr_tl_s, wr_tcon_s, wr_led_s, wr_dig_s;
    logic          ovf_s;
    logic [31:0]   rd_word_s;

    assign ram_idx_s   = AluRes_i[AW+1:2];
    assign word_addr_s = AluRes_i[31:2];
    assign in_ram_s    = (AluRes_i < RAM_BYTES);
    assign wr_en_s     = MemWr_i & ~reset;
    assign ram_we_s    = wr_en_s & in_ram_s;
    assign wr_th_s     = wr_en_s & (word_addr_s == TH_WA);
    assign wr_tl_s     = wr_en_s & (word_addr_s == TL_WA);
    assign wr_tcon_s   = wr_en_s & (word_addr_s == TCON_WA);
    assign wr_led_s    = wr_en_s & (word_addr_s == LED_WA);
    assign wr_dig_s    = wr_en_s & (word_addr_s == DIG_WA);
    assign ovf_s       = tcon_q[0] & (tl_q == 32'hFFFF_FFFF);

    // Combinational read word from RAM or MMIO, then load formatting
    always_comb begin
        rd_word_s = 32'h0000_0000;
        memdata_d = 32'h0000_0000;
        if (in_ram_s) begin
            rd_word_s = ram_q[ram_idx_s];
        end else begin
            case (word_addr_s)
                TH_WA:      rd_word_s = th_q;
                TL_WA:      rd_word_s = tl_q;
                TCON_WA:    rd_word_s = {29'd0, tcon_q};
                LED_WA:     rd_word_s = {24'd0, leds_q};
                DIG_WA:     rd_word_s = {20'd0, digits_q};
                SYSTICK_WA: rd_word_s = systick_q;
                default:    rd_word_s = 32'h0000_0000;
            endcase
        end
        if (!MemRd_i) begin
            memdata_d = 32'h0000_0000;
        end else if (ByteRd_i) begin
            case (AluRes_i[1:0])
                2'd0:    memdata_d = {24'd0, rd_word_s[7:0]};
                2'd1:    memdata_d = {24'd0, rd_word_s[15:8]};
                2'd2:    memdata_d = {24'd0, rd_word_s[23:16]};
                2'd3:    memdata_d = {24'd0, rd_word_s[31:24]};
                default: memdata_d = 32'h0000_0000;
            endcase
        end else begin
            memdata_d = rd_word_s;
        end
    end

    // Timer and MMIO register next state; software writes override count/overflow
    always_comb begin
        th_d       = wr_th_s ? Op2_i : th_q;
        leds_d     = wr_led_s ? Op2_i[7:0] : leds_q;
        digits_d   = wr_dig_s ? Op2_i[11:0] : digits_q;
        systick_d  = systick_q + 32'd1;
        alures_d   = AluRes_i;
        pc_d       = PC_i;
        memtoreg_d = MemtoReg_i;
        regwr_d    = RegWr_i;
        rf_d       = Rf_i;
        if (wr_tl_s) begin
            tl_d = Op2_i;
        end else if (ovf_s) begin
            tl_d = th_q;
        end else if (tcon_q[0]) begin
            tl_d = tl_q + 32'd1;
        end else begin
            tl_d = tl_q;
        end
        if (wr_tcon_s) begin
            tcon_d = Op2_i[2:0];
        end else if (ovf_s && tcon_q[1]) begin
            tcon_d = tcon_q | 3'b100;
        end else begin
            tcon_d = tcon_q;
        end
`ifdef MEM_TIMER_IRQ_EN
        irq_d = tcon_d[1] & tcon_d[2];
`else
        tcon_d[2] = 1'b0;
        irq_d     = 1'b0;
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q       <= 32'h0000_0000;
            tl_q       <= 32'h0000_0000;
            tcon_q     <= 3'b000;
            leds_q     <= 8'h00;
            digits_q   <= 12'h000;
            systick_q  <= 32'h0000_0000;
            irq_q      <= 1'b0;
            memdata_q  <= 32'h0000_0000;
            alures_q   <= 32'h0000_0000;
            pc_q       <= 32'h0000_0000;
            memtoreg_q <= 2'b00;
            regwr_q    <= 1'b0;
            rf_q       <= 5'd0;
        end else begin
            th_q       <= th_d;
            tl_q       <= tl_d;
            tcon_q     <= tcon_d;
            leds_q     <= leds_d;
            digits_q   <= digits_d;
            systick_q  <= systick_d;
            irq_q      <= irq_d;
            memdata_q  <= memdata_d;
            alures_q   <= alures_d;
            pc_q       <= pc_d;
            memtoreg_q <= memtoreg_d;
            regwr_q    <= regwr_d;
            rf_q       <= rf_d;
        end
    end

    // Data RAM keeps its contents through reset; write is gated by reset upstream
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_q[ram_idx_s] <= Op2_i;
        end
    end

    assign MemData_o  = memdata_q;
    assign AluRes_o   = alures_q;
    assign PC_o       = pc_q;
    assign MemtoReg_o = memtoreg_q;
    assign RegWr_o    = regwr_q;
    assign Rf_o       = rf_q;
    assign leds_o     = leds_q;
    assign digits_o   = digits_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_stage;

`ifdef MEM_TIMER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIG  = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] AluRes_i, Op2_i, PC_i;
    logic        MemWr_i, MemRd_i, ByteRd_i;
    logic [1:0]  MemtoReg_i;
    logic        RegWr_i;
    logic [4:0]  Rf_i;
    logic [31:0] MemData_o, AluRes_o, PC_o;
    logic [1:0]  MemtoReg_o;
    logic        RegWr_o;
    logic [4:0]  Rf_o;
    logic [7:0]  leds_o;
    logic [11:0] digits_o;
    logic        irq_o;

    always #5 clk = ~clk;

    mem_stage #(.RAM_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .AluRes_i(AluRes_i), .Op2_i(Op2_i), .PC_i(PC_i),
        .MemWr_i(MemWr_i), .MemRd_i(MemRd_i), .ByteRd_i(ByteRd_i),
        .MemtoReg_i(MemtoReg_i), .RegWr_i(RegWr_i), .Rf_i(Rf_i),
        .MemData_o(MemData_o), .AluRes_o(AluRes_o), .PC_o(PC_o),
        .MemtoReg_o(MemtoReg_o), .RegWr_o(RegWr_o), .Rf_o(Rf_o),
        .leds_o(leds_o), .digits_o(digits_o), .irq_o(irq_o)
    );

    // Reference model state
    logic [31:0] m_mem [256];
    bit          m_val [256];
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_leds;
    logic [11:0] m_dig;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (a < 32'd1024) begin
            known = m_val[a[9:2]];
            return m_mem[a[9:2]];
        end
        case ({a[31:2], 2'b00})
            A_TH:    return m_th;
            A_TL:    return m_tl;
            A_TCON:  return {29'd0, m_tcon};
            A_LED:   return {24'd0, m_leds};
            A_DIG:   return {20'd0, m_dig};
            A_TICK:  return m_tick;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive a transaction, advance the model, compare every registered output
    task automatic step(input logic [31:0] addr, input logic [31:0] data,
                        input bit wr, input bit rd, input bit br, input bit rst);
        logic [31:0] e_data, w, e_pc, e_alu;
        logic [31:0] n_th, n_tl;
        logic [2:0]  n_tcon;
        logic [7:0]  n_leds;
        logic [11:0] n_dig;
        logic [7:0]  e_pass;
        bit          known, ovf;
        AluRes_i   = addr;
        Op2_i      = data;
        MemWr_i    = wr;
        MemRd_i    = rd;
        ByteRd_i   = br;
        reset      = rst;
        PC_i       = $urandom;
        MemtoReg_i = 2'($urandom);
        RegWr_i    = 1'($urandom);
        Rf_i       = 5'($urandom);
        e_pc       = PC_i;
        e_alu      = addr;
        e_pass     = {MemtoReg_i, RegWr_i, Rf_i};
        known      = 1'b1;
        e_data     = 32'd0;
        if (rd) begin
            w = ref_word(addr, known);
            e_data = br ? ((w >> (8 * addr[1:0])) & 32'hFF) : w;
        end
        ovf    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
        n_th   = m_th;
        n_tl   = ovf ? m_th : (m_tcon[0] ? m_tl + 32'd1 : m_tl);
        n_tcon = m_tcon;
        if (ovf && m_tcon[1] && IRQ_EN) n_tcon[2] = 1'b1;
        n_leds = m_leds;
        n_dig  = m_dig;
        if (wr && !rst) begin
            if (addr < 32'd1024) begin
                m_mem[addr[9:2]] = data;
                m_val[addr[9:2]] = 1'b1;
            end else begin
                case ({addr[31:2], 2'b00})
                    A_TH:    n_th = data;
                    A_TL:    n_tl = data;
                    A_TCON:  begin
                        n_tcon = data[2:0];
                        if (!IRQ_EN) n_tcon[2] = 1'b0;
                    end
                    A_LED:   n_leds = data[7:0];
                    A_DIG:   n_dig = data[11:0];
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_leds = 0; m_dig = 0; m_tick = 0;
            e_data = 0; e_pc = 0; e_alu = 0; e_pass = 0; known = 1'b1;
        end else begin
            m_th = n_th; m_tl = n_tl; m_tcon = n_tcon; m_leds = n_leds; m_dig = n_dig;
            m_tick = m_tick + 32'd1;
        end
        if (known) check_eq("memdata", MemData_o, e_data);
        check_eq("alures", AluRes_o, e_alu);
        check_eq("pc", PC_o, e_pc);
        check_eq("passthru", {24'd0, MemtoReg_o, RegWr_o, Rf_o}, {24'd0, e_pass});
        check_eq("leds", {24'd0, leds_o}, {24'd0, m_leds});
        check_eq("digits", {20'd0, digits_o}, {20'd0, m_dig});
        check_eq("irq", {31'd0, irq_o}, {31'd0, m_tcon[1] & m_tcon[2]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, d;
        int          sel;
        bit          wr, rd, br, rst;
        m_th = 0; m_tl = 0; m_tcon = 0; m_leds = 0; m_dig = 0; m_tick = 0;

        step(32'h0, 32'h0, 0, 0, 0, 1);
        step(32'h0, 32'h0, 0, 0, 0, 1);

        // Word store/load and byte loads
        step(32'h10, 32'h1234_5678, 1, 0, 0, 0);
        step(32'h10, 32'h0, 0, 1, 0, 0);
        check_eq("word_load", MemData_o, 32'h1234_5678);
        step(32'h12, 32'h0, 0, 1, 1, 0);
        check_eq("byte_load_12", MemData_o, 32'h0000_0034);
        step(32'h13, 32'h0, 0, 1, 1, 0);
        check_eq("byte_load_13", MemData_o, 32'h0000_0012);
        // Same-cycle read and write returns the old word
        step(32'h10, 32'hCAFE_F00D, 1, 1, 0, 0);
        check_eq("rd_before_wr", MemData_o, 32'h1234_5678);
        step(32'h10, 32'h1234_5678, 1, 0, 0, 0);

        // LEDs and digits
        step(A_LED, 32'h0000_00A5, 1, 0, 0, 0);
        step(A_DIG, 32'hFFFF_FFFF, 1, 0, 0, 0);
        step(A_LED, 32'h0, 0, 1, 0, 0);
        check_eq("leds_a5", {24'd0, leds_o}, 32'hA5);
        check_eq("digits_fff", {20'd0, digits_o}, 32'hFFF);
        check_eq("led_load", MemData_o, 32'h0000_00A5);

        // Timer overflow and reload
        step(A_TH, 32'hFFFF_FFFE, 1, 0, 0, 0);
        step(A_TL, 32'hFFFF_FFFE, 1, 0, 0, 0);
        step(A_TCON, 32'h3, 1, 0, 0, 0);
        step(A_TL, 32'h0, 0, 1, 0, 0);
        check_eq("tl_start", MemData_o, 32'hFFFF_FFFE);
        step(A_TL, 32'h0, 0, 1, 0, 0);
        check_eq("tl_max", MemData_o, 32'hFFFF_FFFF);
        check_eq("irq_set", {31'd0, irq_o}, {31'd0, IRQ_EN});
        step(A_TL, 32'h0, 0, 1, 0, 0);
        check_eq("tl_reload", MemData_o, 32'hFFFF_FFFE);
        step(A_TCON, 32'h3, 1, 0, 0, 0);
        check_eq("irq_clear", {31'd0, irq_o}, 32'd0);

        // Software TL write beats the count
        step(A_TL, 32'd5, 1, 0, 0, 0);
        step(A_TL, 32'h0, 0, 1, 0, 0);
        check_eq("tl_write_prio", MemData_o, 32'd5);

        // Reset mid-count with a coincident store
        step(32'h10, 32'hDEAD_BEEF, 1, 1, 0, 1);
        check_eq("rst_leds", {24'd0, leds_o}, 32'd0);
        check_eq("rst_memdata", MemData_o, 32'd0);
        step(32'h10, 32'h0, 0, 1, 0, 0);
        check_eq("ram_kept", MemData_o, 32'h1234_5678);
        step(A_TL, 32'h0, 0, 1, 0, 0);
        step(A_TL, 32'h0, 0, 1, 0, 0);
        check_eq("timer_stopped", MemData_o, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            sel = $urandom_range(0, 9);
            wr  = ($urandom_range(0, 9) < 4);
            rd  = ($urandom_range(0, 9) < 6);
            br  = $urandom_range(0, 1);
            rst = ($urandom_range(0, 199) == 0);
            d   = $urandom;
            if (sel < 5) begin
                a = $urandom_range(0, 63);
            end else if (sel < 9) begin
                a = 32'h4000_0000 + 32'(4 * $urandom_range(0, 6));
                if (a == A_TL && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                if (a == A_TH && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0;
                if (a == A_TCON && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 7));
                if (br) a = a + 32'($urandom_range(0, 3));
            end else begin
                a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 + 32'($urandom_range(0, 255))
                                                 : 32'd1024 + 32'($urandom_range(0, 255));
            end
            step(a, d, wr, rd, br, rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
